// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: AHB-Lite initiator issuing a command as pipelined back-to-back NONSEQ single transfers
module ahb_cmd_master #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_addr,
  input  logic                 cmd_write,
  input  logic [2:0]           cmd_size,
  input  logic [CNT_WIDTH-1:0] cmd_len,
  input  logic [31:0]          wr_data,
  output logic                 wr_pop,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  // ERR covers the second cycle of a two-cycle ERROR response
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic accept, in_data, addr_done, data_ok, err_first, err_end, more;
  // state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else state <= state_nx;
  end
  // phase decode and next state; an ERROR first cycle blocks completion of the pending address phase
  always_comb begin
    in_data = state == S_PIPE || state == S_LAST;
    accept = cmd_valid && state == S_IDLE;
    addr_done = HREADY && (state == S_ADDR || (state == S_PIPE && !HRESP));
    data_ok = HREADY && !HRESP && in_data;
    err_first = in_data && HRESP && !HREADY;
    err_end = HREADY && (state == S_ERR || (in_data && HRESP));
    more = cnt != '0;
    state_nx = accept ? S_ADDR :
               (err_end || (data_ok && state == S_LAST)) ? S_IDLE :
               err_first ? S_ERR :
               addr_done ? (more ? S_PIPE : S_LAST) : state;
  end
  // command handshake, write-source pop and the fixed burst type
  always_comb begin
    cmd_ready = state == S_IDLE;
    wr_pop = addr_done && HWRITE;
    HBURST = 3'b000;
  end
  // registered bus outputs, beat counter and completion pulses
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HADDR <= '0;
      HTRANS <= HT_IDLE;
      HWRITE <= 1'b0;
      HSIZE <= '0;
      HWDATA <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      rd_valid <= data_ok && !HWRITE;
      done <= err_end || (data_ok && state == S_LAST);
      err <= err_end;
      if (accept) begin
        HADDR <= cmd_addr;
        HTRANS <= HT_NONSEQ;
        HWRITE <= cmd_write;
        HSIZE <= cmd_size;
        cnt <= cmd_len;
      end
      if (addr_done && HWRITE) HWDATA <= wr_data;
      if (addr_done && more) begin
        HADDR <= HADDR + (32'd1 << HSIZE);
        cnt <= cnt - CNT_WIDTH'(1);
      end
      if ((addr_done && !more) || err_first || err_end) HTRANS <= HT_IDLE;
      if (data_ok && !HWRITE) rd_data <= HRDATA;
    end
  end
endmodule
